// File: rtl/digit_serial_adder_if.sv
// Handshake and data bundle for digit_serial_adder: request side drives operands and start,
// the adder returns status and the registered result.
interface digit_serial_adder_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, overflow
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, overflow
    );
endinterface

// File: rtl/digit_serial_adder.sv
// Digit-serial adder: adds two WIDTH-bit operands plus carry-in DIGIT bits per clock through a
// registered inter-digit carry, with a start/busy/done handshake.
module digit_serial_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    digit_serial_adder_if.slave io_bus
);
    localparam int unsigned NDIG = WIDTH / DIGIT;
    localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_a, w_a_nxt;
    logic [WIDTH-1:0] r_b, w_b_nxt;
    logic [WIDTH-1:0] r_acc, w_acc_nxt;
    logic [WIDTH-1:0] r_sum, w_sum_nxt;
    logic             r_carry, w_carry_nxt;
    logic             r_cout, w_cout_nxt;
    logic             r_ovf, w_ovf_nxt;
    logic [CW-1:0]    r_cnt, w_cnt_nxt;

    logic [DIGIT:0]   w_dig;
    logic [WIDTH-1:0] w_acc_shift;
    logic             w_last;

    assign w_dig = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]} + (DIGIT+1)'(r_carry);
    // New digit enters at the top so the sum is aligned once all digits are in.
    assign w_acc_shift = (r_acc >> DIGIT) | (WIDTH'(w_dig[DIGIT-1:0]) << (WIDTH - DIGIT));
    assign w_last      = (r_cnt == CW'(NDIG - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_acc_nxt   = r_acc;
        w_sum_nxt   = r_sum;
        w_carry_nxt = r_carry;
        w_cout_nxt  = r_cout;
        w_ovf_nxt   = r_ovf;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            StIdle, StDone: begin
                if (io_bus.start) begin
                    w_a_nxt     = io_bus.a;
                    w_b_nxt     = io_bus.b;
                    w_carry_nxt = io_bus.cin;
                    w_acc_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = StRun;
                end else begin
                    w_state_nxt = StIdle;
                end
            end
            StRun: begin
                w_a_nxt     = r_a >> DIGIT;
                w_b_nxt     = r_b >> DIGIT;
                w_acc_nxt   = w_acc_shift;
                w_carry_nxt = w_dig[DIGIT];
                w_cnt_nxt   = r_cnt + CW'(1);
                if (w_last) begin
                    // On the final digit the operand registers hold the original MSBs.
                    w_sum_nxt   = w_acc_shift;
                    w_cout_nxt  = w_dig[DIGIT];
                    w_ovf_nxt   = (r_a[DIGIT-1] == r_b[DIGIT-1]) &&
                                  (w_dig[DIGIT-1] != r_a[DIGIT-1]);
                    w_state_nxt = StDone;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_acc   <= w_acc_nxt;
            r_sum   <= w_sum_nxt;
            r_carry <= w_carry_nxt;
            r_cout  <= w_cout_nxt;
            r_ovf   <= w_ovf_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign io_bus.busy     = (r_state == StRun);
    assign io_bus.done     = (r_state == StDone);
    assign io_bus.sum      = r_sum;
    assign io_bus.cout     = r_cout;
    assign io_bus.overflow = r_ovf;
endmodule

// File: tb/tb_digit_serial_adder.sv
// Bench for digit_serial_adder: directed handshake/reset cases on a 16/4 instance plus random
// sweeps on 16/1, 16/16, 32/8 and 8/2 instances against an integer reference model.
module tb_digit_serial_adder;
    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic rst_s = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   sweeps_done = 0;

    logic [15:0] hold_sum;
    logic        hold_cout;
    logic        hold_ovf;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer addition, overflow as signed-range violation.
    task automatic ref_add(input longint a, input longint b, input longint c, input int w,
                           output longint s, output bit co, output bit ov);
        longint m, full, sa, sb, ss;
        m    = longint'(1) <<< w;
        full = a + b + c;
        s    = full % m;
        co   = (full >= m);
        sa   = (a >= m / 2) ? a - m : a;
        sb   = (b >= m / 2) ? b - m : b;
        ss   = sa + sb + c;
        ov   = (ss >= m / 2) || (ss < -(m / 2));
    endtask

    digit_serial_adder_if #(.WIDTH(16)) u_if ();

    digit_serial_adder #(.WIDTH(16), .DIGIT(4)) u_dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (u_if)
    );

    // Issue one operation at a negedge; returns at the negedge of the done cycle.
    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic c,
                        input logic [15:0] es, input logic ec, input logic eo,
                        input bit keep_start);
        u_if.start = 1'b1;
        u_if.a     = a;
        u_if.b     = b;
        u_if.cin   = c;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            u_if.start = keep_start;
            u_if.a     = 16'($urandom);
            u_if.b     = 16'($urandom);
            u_if.cin   = 1'($urandom);
            check("busy_run", u_if.busy, 1);
            check("done_run", u_if.done, 0);
            check("sum_held_run", u_if.sum, hold_sum);
        end
        @(negedge clk);
        check("done_pulse", u_if.done, 1);
        check("busy_done", u_if.busy, 0);
        check("sum", u_if.sum, es);
        check("cout", u_if.cout, ec);
        check("overflow", u_if.overflow, eo);
        hold_sum  = es;
        hold_cout = ec;
        hold_ovf  = eo;
    endtask

    task automatic idle_step();
        u_if.start = 1'b0;
        @(negedge clk);
        check("done_idle", u_if.done, 0);
        check("busy_idle", u_if.busy, 0);
        check("sum_idle", u_if.sum, hold_sum);
        check("cout_idle", u_if.cout, hold_cout);
        check("ovf_idle", u_if.overflow, hold_ovf);
    endtask

    task automatic rand_op16(input bit keep_start);
        logic [15:0] ra, rb;
        logic        rc;
        longint      s;
        bit          co, ov;
        ra = 16'($urandom);
        rb = 16'($urandom);
        rc = 1'($urandom);
        ref_add(longint'(ra), longint'(rb), longint'(rc), 16, s, co, ov);
        op16(ra, rb, rc, 16'(s), co, ov, keep_start);
    endtask

    for (genvar g = 0; g < 4; g++) begin : g_sweep
        localparam int unsigned W = (g == 0) ? 16 : (g == 1) ? 16 : (g == 2) ? 32 : 8;
        localparam int unsigned D = (g == 0) ? 1 : (g == 1) ? 16 : (g == 2) ? 8 : 2;
        localparam int unsigned N = W / D;

        digit_serial_adder_if #(.WIDTH(W)) s_if ();

        digit_serial_adder #(.WIDTH(W), .DIGIT(D)) s_dut (
            .clk    (clk),
            .rst    (rst_s),
            .io_bus (s_if)
        );

        initial begin
            logic [W-1:0] ra, rb;
            logic         rc;
            longint       s;
            bit           co, ov;
            int           lat;
            string        tag;
            tag        = $sformatf("w%0d_d%0d", W, D);
            s_if.start = 1'b0;
            s_if.a     = '0;
            s_if.b     = '0;
            s_if.cin   = 1'b0;
            while (rst_s) @(negedge clk);
            for (int n = 0; n < 1000; n++) begin
                ra = W'($urandom);
                rb = W'($urandom);
                rc = 1'($urandom);
                ref_add(longint'(ra), longint'(rb), longint'(rc), W, s, co, ov);
                s_if.start = 1'b1;
                s_if.a     = ra;
                s_if.b     = rb;
                s_if.cin   = rc;
                lat = 0;
                for (int c = 1; c <= int'(N) + 3; c++) begin
                    @(negedge clk);
                    s_if.start = 1'b0;
                    s_if.a     = W'($urandom);
                    s_if.b     = W'($urandom);
                    if (s_if.done) begin
                        lat = c;
                        break;
                    end
                end
                check({tag, "_latency"}, lat, N + 1);
                check({tag, "_sum"}, s_if.sum, 64'(s));
                check({tag, "_cout"}, s_if.cout, co);
                check({tag, "_ovf"}, s_if.overflow, ov);
                if ($urandom_range(3) == 0) @(negedge clk);
            end
            sweeps_done++;
        end
    end

    initial begin
        u_if.start = 1'b0;
        u_if.a     = '0;
        u_if.b     = '0;
        u_if.cin   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", u_if.busy, 0);
        check("rst_done", u_if.done, 0);
        check("rst_sum", u_if.sum, 0);
        check("rst_cout", u_if.cout, 0);
        check("rst_ovf", u_if.overflow, 0);
        // Reset must beat a simultaneous start.
        u_if.start = 1'b1;
        u_if.a     = 16'h1111;
        @(negedge clk);
        check("rst_over_start", u_if.busy, 0);
        rst        = 1'b0;
        rst_s      = 1'b0;
        u_if.start = 1'b0;
        hold_sum   = '0;
        hold_cout  = 1'b0;
        hold_ovf   = 1'b0;
        idle_step();

        op16(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
        idle_step();
        op16(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        idle_step();
        op16(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        idle_step();
        op16(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        idle_step();
        op16(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
        idle_step();

        // start held high: each op begins in the previous op's done cycle.
        for (int i = 0; i < 4; i++) rand_op16(1'b1);
        idle_step();

        // Reset in cycle 2 of a run abandons it with no done pulse.
        op16(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
        idle_step();
        u_if.start = 1'b1;
        u_if.a     = 16'h0F0F;
        u_if.b     = 16'h0101;
        u_if.cin   = 1'b1;
        @(negedge clk);
        u_if.start = 1'b0;
        check("busy_before_rst", u_if.busy, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_busy", u_if.busy, 0);
        check("midrst_done", u_if.done, 0);
        check("midrst_sum", u_if.sum, 0);
        check("midrst_cout", u_if.cout, 0);
        check("midrst_ovf", u_if.overflow, 0);
        hold_sum  = '0;
        hold_cout = 1'b0;
        hold_ovf  = 1'b0;
        for (int i = 0; i < 6; i++) idle_step();
        rand_op16(1'b0);
        idle_step();
        for (int i = 0; i < 6; i++) begin
            rand_op16(1'b0);
            if (i[0]) idle_step();
        end
        idle_step();

        for (int i = 0; i < 40000 && sweeps_done < 4; i++) @(negedge clk);
        check("sweeps_finished", sweeps_done, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
